sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO with independent read and write in the same cycle, programmable almost-full and almost-empty thresholds, an occupancy count output, and sticky overflow and underflow error flags. It is the drop-in general-purpose buffer for all single-clock datapaths in the design. It replaces the fixed 8-bit × 16 FIFO, whose reads and writes were mutually exclusive.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- wr  in  1  write request
- din  in  WIDTH  write data, sampled with wr
- rd  in  1  read request
- dout  out  WIDTH  registered read data
- dout_valid  out  1  one-cycle pulse: dout updated by an accepted read
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- overflow  out  1  sticky; a write was rejected
- underflow  out  1  sticky; a read was rejected

## Operation
- Storage: DEPTH × WIDTH array. wptr and rptr are log2(DEPTH) bits wide, wrap naturally from DEPTH-1 to 0. count is a separate register.
- Write accept: wr_ok = wr && !full. full is taken from the registered count. On wr_ok, mem[wptr] ← din and wptr increments.
- Read accept: rd_ok = rd && !empty. empty is taken from the registered count. On rd_ok, dout ← mem[rptr], rptr increments, and dout_valid = 1 for one cycle.
- When no read is accepted, dout holds its value and dout_valid = 0.
- count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- Simultaneous wr and rd:
  - 0 < count < DEPTH: both accepted; count unchanged.
  - Empty: write accepted; read rejected (no fall-through); underflow sets.
  - Full: read accepted; write rejected, even though a slot frees this cycle; overflow sets.
- overflow sets on wr && full; underflow sets on rd && empty. Both hold until rst.
- Status flags are combinational decodes of the count register only, never of wr or rd.
- Reset (rst = 1 at an edge) has priority over all other inputs:
  - wptr, rptr, count, dout, dout_valid, overflow, underflow ← 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data. Any wr or rd in the reset cycle is ignored and does not set the error flags.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) must be flagged by an elaboration-time check.

## Timing
- Outputs after reset: dout = 0, dout_valid = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_LEVEL ≥ 1), overflow = 0, underflow = 0.
- Write latency: write accepted at edge N → count, empty and almost flags reflect it after edge N.
  - A rd asserted in the cycle after edge N is accepted at edge N+1.
  - The written word appears on dout after edge N+1.
- Read latency: 1 cycle. rd accepted at edge N → dout and dout_valid valid after edge N. dout_valid drops after N+1 unless another read is accepted.
- Sustained throughput: one write and one read per cycle while 0 < count < DEPTH.
- Error flags assert the cycle after the offending edge and stay asserted.

## Test plan
- Reset check: assert rst for 2 cycles with wr = rd = 1 → count = 0, empty = 1, dout = 0, overflow = underflow = 0.
- Fill and overflow: 17 consecutive writes of 0x00..0x10.
  - count reaches 16 and full = 1.
  - almost_full first = 1 after the 12th write.
  - 17th write is dropped and overflow = 1.
- Drain and underflow: 16 reads.
  - dout yields 0x00..0x0F in order, with one dout_valid pulse per read.
  - almost_empty = 1 once count ≤ 2.
  - A 17th read leaves dout = 0x0F, dout_valid = 0, underflow = 1.
- Simultaneous access:
  - With count = 5, hold wr = rd = 1 for 20 cycles → count stays 5, output order is preserved, and pointers wrap past 15 with no data corruption.
- Boundary simultaneous:
  - Full + wr + rd → count = 15, overflow = 1.
  - Empty + wr + rd → count = 1, underflow = 1, dout unchanged.
- Mid-operation reset:
  - With count = 9, pulse rst for 1 cycle → count = 0, empty = 1, flags cleared.
  - The next write of 0xA5 followed by a read returns 0xA5.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Purpose  : Parametrised single-clock FIFO. A read and a write can both be
//             accepted in the same cycle. Provides programmable almost-full
//             and almost-empty thresholds, an occupancy count, a registered
//             read port, and sticky overflow/underflow error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0] c_af      = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_ae      = CW'(AE_LEVEL);

    // Parameter legality is checked at elaboration so a bad instance never builds.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_wr_ok;
    logic w_rd_ok;

    // Status flags decode only the registered count, never the requests.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // A full FIFO rejects writes even if a read frees a slot this cycle;
    // an empty FIFO rejects reads even if a write arrives (no fall-through).
    assign w_wr_ok = wr && !w_full;
    assign w_rd_ok = rd && !w_empty;

    // Storage array is not reset; stale contents are unreachable after rst.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers, occupancy, read port and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= r_rptr + c_ptr_one;
            end
            r_dout_valid <= w_rd_ok;

            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= c_ae);
    assign almost_full  = (r_count >= c_af);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Purpose  : Self-checking bench for sync_fifo_param (default parameters).
//             Directed vector table, hand-written corner sequences and a
//             randomized run, all compared against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 2;

    logic             clk;
    logic             rst;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [4:0]       count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: a queue of stored words plus the visible registers.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_dout;
    bit               m_dv;
    bit               m_ov;
    bit               m_un;

    typedef struct {
        bit               rst;
        bit               wr;
        bit               rd;
        logic [WIDTH-1:0] din;
        int               exp_count;
        logic [WIDTH-1:0] exp_dout;
        bit               exp_dv;
        bit               exp_ov;
        bit               exp_un;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit w, input bit rdq, input logic [WIDTH-1:0] d);
        int  n;
        bit  rd_ok;
        bit  wr_ok;
        n = m_q.size();
        if (r) begin
            m_q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ov   = 1'b0;
            m_un   = 1'b0;
        end else begin
            rd_ok = rdq && (n != 0);
            wr_ok = w && (n != DEPTH);
            if (w && n == DEPTH) m_ov = 1'b1;
            if (rdq && n == 0)   m_un = 1'b1;
            m_dv = rd_ok;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
        end
    endtask

    task automatic compare_model();
        int n;
        n = m_q.size();
        chk("count",        int'(count),        n);
        chk("empty",        int'(empty),        int'(n == 0));
        chk("full",         int'(full),         int'(n == DEPTH));
        chk("almost_empty", int'(almost_empty), int'(n <= AE_LEVEL));
        chk("almost_full",  int'(almost_full),  int'(n >= AF_LEVEL));
        chk("overflow",     int'(overflow),     int'(m_ov));
        chk("underflow",    int'(underflow),    int'(m_un));
        chk("dout_valid",   int'(dout_valid),   int'(m_dv));
        chk("dout",         int'(dout),         int'(m_dout));
    endtask

    // One clock: drive, clock, sample #1 after the edge, compare to model.
    task automatic step(input bit r, input bit w, input bit rdq, input logic [WIDTH-1:0] d);
        rst = r;
        wr  = w;
        rd  = rdq;
        din = d;
        @(posedge clk);
        #1;
        model_update(r, w, rdq, d);
        compare_model();
    endtask

    task automatic add_vec(input bit r, input bit w, input bit rdq, input logic [WIDTH-1:0] d,
                           input int ec, input logic [WIDTH-1:0] ed, input bit edv,
                           input bit eov, input bit eun);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rdq; v.din = d;
        v.exp_count = ec; v.exp_dout = ed; v.exp_dv = edv;
        v.exp_ov = eov; v.exp_un = eun;
        vecs.push_back(v);
    endtask

    logic [WIDTH-1:0] first_word;

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
        m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;

        // Directed table: reset with requests, fill + overflow, drain + underflow.
        add_vec(1, 1, 1, 8'hFF, 0, 8'h00, 0, 0, 0);
        add_vec(1, 1, 1, 8'hEE, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add_vec(0, 1, 0, 8'(i), i + 1, 8'h00, 0, 0, 0);
        add_vec(0, 1, 0, 8'h10, 16, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++)
            add_vec(0, 0, 1, 8'h00, 15 - i, 8'(i), 1, 1, 0);
        add_vec(0, 0, 1, 8'h00, 0, 8'h0F, 0, 1, 1);
        add_vec(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst, vecs[k].wr, vecs[k].rd, vecs[k].din);
            chk("tbl_count",  int'(count),       vecs[k].exp_count);
            chk("tbl_dout",   int'(dout),        int'(vecs[k].exp_dout));
            chk("tbl_dv",     int'(dout_valid),  int'(vecs[k].exp_dv));
            chk("tbl_ov",     int'(overflow),    int'(vecs[k].exp_ov));
            chk("tbl_un",     int'(underflow),   int'(vecs[k].exp_un));
            chk("tbl_empty",  int'(empty),       int'(vecs[k].exp_count == 0));
            chk("tbl_full",   int'(full),        int'(vecs[k].exp_count == DEPTH));
            chk("tbl_afull",  int'(almost_full), int'(vecs[k].exp_count >= AF_LEVEL));
            chk("tbl_aempty", int'(almost_empty),int'(vecs[k].exp_count <= AE_LEVEL));
        end

        // Simultaneous access at count 5 for 20 cycles; pointers wrap past 15.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 8'(8'h50 + i));
            chk("simul_count", int'(count), 5);
            chk("simul_dv",    int'(dout_valid), 1);
        end
        chk("simul_last_dout", int'(dout), 8'h5E);

        // Full + wr + rd: read accepted, write dropped, overflow set.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'hA0 + i));
        first_word = 8'hA0;
        step(0, 1, 1, 8'hCC);
        chk("full_wr_rd_count", int'(count), 15);
        chk("full_wr_rd_ov",    int'(overflow), 1);
        chk("full_wr_rd_dout",  int'(dout), int'(first_word));

        // Empty + wr + rd: write accepted, read rejected, dout held.
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h3C);
        step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h77);
        chk("empty_wr_rd_count", int'(count), 1);
        chk("empty_wr_rd_un",    int'(underflow), 1);
        chk("empty_wr_rd_dout",  int'(dout), 8'h3C);
        chk("empty_wr_rd_dv",    int'(dout_valid), 0);

        // Mid-operation reset at count 9 after flags were set.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(i));
        chk("pre_rst_count", int'(count), 9);
        step(1, 1, 1, 8'h99);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_un",    int'(underflow), 0);
        step(0, 1, 0, 8'hA5);
        step(0, 0, 1, 8'h00);
        chk("post_rst_dout", int'(dout), 8'hA5);
        chk("post_rst_dv",   int'(dout_valid), 1);

        // Randomized traffic against the model, with biased phases and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int  phase;
            bit  r, w, q;
            phase = (i / 200) % 3;
            r = ($urandom_range(0, 127) == 0);
            case (phase)
                0:       begin w = ($urandom_range(0, 3) != 0); q = ($urandom_range(0, 3) == 0); end
                1:       begin w = ($urandom_range(0, 3) == 0); q = ($urandom_range(0, 3) != 0); end
                default: begin w = $urandom_range(0, 1) != 0;   q = $urandom_range(0, 1) != 0;   end
            endcase
            step(r, w, q, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
